tjmonopix2_cmd_tx: RTL and testbench

//  FPGA-side command transmitter driving the chip's LVDS_CMD input, one bit per CLK, 16-bit frames, MSB first.
//  It accepts user command frames over a valid/ready handshake and fills idle slots with NOOP frames.
//  It forces a SYNC frame periodically and after reset, so the chip command decoder stays locked.
//  It sits between the command sequencer/FIFO and the LVDS_CMD output pin.

---
 rtl/tjmonopix2_cmd_tx.sv | 106 ++++++++++
 tb/tb_tjmonopix2_cmd_tx.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tjmonopix2_cmd_tx.sv
// Serial command transmitter for the TJ-Monopix2 LVDS_CMD input.
// A free-running 16-cycle frame slot sends one frame MSB first. At the end of
// each slot it picks the next frame in priority order:
//   1. a forced SYNC,
//   2. an accepted user frame,
//   3. a NOOP filler.
// The SYNC cadence keeps the chip-side command decoder locked.
module tjmonopix2_cmd_tx #(
    parameter int unsigned SYNC_INTERVAL = 32,
    parameter logic [15:0] SYNC_WORD     = 16'h817E,
    parameter logic [15:0] NOOP_WORD     = 16'h6969
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        EN,
    input  logic [15:0] FRAME_DATA,
    input  logic        FRAME_VALID,
    output logic        FRAME_READY,
    output logic        CMD_OUT,
    output logic        BUSY,
    output logic [15:0] FRAME_CNT
);

    localparam int unsigned SW = $clog2(SYNC_INTERVAL);
    localparam logic [SW-1:0] SYNC_MAX = SW'(SYNC_INTERVAL - 1);

    logic [3:0]    bitCnt_q, bitCnt_d;
    logic [SW-1:0] syncCnt_q, syncCnt_d;
    logic [15:0]   shift_q, shift_d;
    logic          cmd_q, cmd_d;
    logic          busy_q, busy_d;
    logic [15:0]   frameCnt_q, frameCnt_d;

    logic          loadCycle;
    logic          forceSync;
    logic          accept;
    logic [15:0]   nextFrame;

    // The last bit slot of a frame doubles as the load slot for the next frame.
    assign loadCycle   = (bitCnt_q == 4'd15);
    assign forceSync   = (syncCnt_q == SYNC_MAX);
    assign FRAME_READY = loadCycle && EN && !forceSync && !RST;
    assign accept      = FRAME_READY && FRAME_VALID;

    assign CMD_OUT   = cmd_q;
    assign BUSY      = busy_q;
    assign FRAME_CNT = frameCnt_q;

    // Priority selection of the frame to load on a load cycle.
    always_comb begin
        nextFrame = NOOP_WORD;
        if (forceSync) begin
            nextFrame = SYNC_WORD;
        end else if (accept) begin
            nextFrame = FRAME_DATA;
        end
    end

    // Next-state logic: load a fresh frame on the load cycle, otherwise shift out.
    always_comb begin
        bitCnt_d   = bitCnt_q;
        syncCnt_d  = syncCnt_q;
        shift_d    = shift_q;
        cmd_d      = cmd_q;
        busy_d     = busy_q;
        frameCnt_d = frameCnt_q;
        if (loadCycle) begin
            bitCnt_d = 4'd0;
            cmd_d    = nextFrame[15];
            shift_d  = {nextFrame[14:0], 1'b0};
            busy_d   = accept;
            if (nextFrame == SYNC_WORD) begin
                syncCnt_d = '0;
            end else if (syncCnt_q != SYNC_MAX) begin
                syncCnt_d = syncCnt_q + 1'b1;
            end
            if (accept) begin
                frameCnt_d = frameCnt_q + 16'd1;
            end
        end else begin
            bitCnt_d = bitCnt_q + 4'd1;
            cmd_d    = shift_q[15];
            shift_d  = {shift_q[14:0], 1'b0};
        end
    end

    // State registers; reset aborts any frame in flight and re-arms the SYNC.
    always_ff @(posedge CLK) begin
        if (RST) begin
            bitCnt_q   <= 4'd15;
            syncCnt_q  <= SYNC_MAX;
            shift_q    <= '0;
            cmd_q      <= 1'b0;
            busy_q     <= 1'b0;
            frameCnt_q <= '0;
        end else begin
            bitCnt_q   <= bitCnt_d;
            syncCnt_q  <= syncCnt_d;
            shift_q    <= shift_d;
            cmd_q      <= cmd_d;
            busy_q     <= busy_d;
            frameCnt_q <= frameCnt_d;
        end
    end

endmodule

// File: tb/tb_tjmonopix2_cmd_tx.sv
// Directed and randomized bench for tjmonopix2_cmd_tx.
// The reference model works at frame level. On every 16th cycle after reset it
// picks a whole frame from the selection rules and queues its 16 bits. Each
// cycle then pops one bit and compares it against CMD_OUT.
module tb_tjmonopix2_cmd_tx;

    localparam int          SI     = 32;
    localparam logic [15:0] SYNC_W = 16'h817E;
    localparam logic [15:0] NOOP_W = 16'h6969;

    logic        CLK         = 1'b0;
    logic        RST         = 1'b1;
    logic        EN          = 1'b0;
    logic        FRAME_VALID = 1'b0;
    logic [15:0] FRAME_DATA  = 16'h0000;
    logic        FRAME_READY;
    logic        CMD_OUT;
    logic        BUSY;
    logic [15:0] FRAME_CNT;

    // Free-running bit clock.
    always #5 CLK = ~CLK;

    tjmonopix2_cmd_tx #(
        .SYNC_INTERVAL(SI),
        .SYNC_WORD    (SYNC_W),
        .NOOP_WORD    (NOOP_W)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .EN         (EN),
        .FRAME_DATA (FRAME_DATA),
        .FRAME_VALID(FRAME_VALID),
        .FRAME_READY(FRAME_READY),
        .CMD_OUT    (CMD_OUT),
        .BUSY       (BUSY),
        .FRAME_CNT  (FRAME_CNT)
    );

    int          checks = 0;
    int          errors = 0;

    int          cyc;
    int          sinceSync;
    logic [15:0] mCnt;
    logic        mCmd;
    logic        mBusy;
    logic        lastAccept;
    bit          bitQ[$];

    logic [15:0] seenBits = 16'h0000;
    int          dutAccepts;
    int          dutAcceptCycle;
    int          dutAcc32Cycle;

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        cyc        = 0;
        sinceSync  = SI - 1;
        mCnt       = 16'h0000;
        mCmd       = 1'b0;
        mBusy      = 1'b0;
        lastAccept = 1'b0;
        bitQ.delete();
        dutAccepts = 0;
    endtask

    task automatic modelAdvance();
        logic [15:0] word;
        logic        user;
        lastAccept = 1'b0;
        if (RST) begin
            modelReset();
        end else begin
            if ((cyc % 16) == 0) begin
                user = 1'b0;
                if (sinceSync >= SI - 1) begin
                    word = SYNC_W;
                end else if (EN && FRAME_VALID) begin
                    word = FRAME_DATA;
                    user = 1'b1;
                end else begin
                    word = NOOP_W;
                end
                if (user) begin
                    mCnt       = mCnt + 16'd1;
                    lastAccept = 1'b1;
                end
                if (word == SYNC_W) sinceSync = 0;
                else if (sinceSync < SI - 1) sinceSync = sinceSync + 1;
                bitQ.delete();
                for (int i = 15; i >= 0; i--) bitQ.push_back(word[i]);
                mBusy = user;
            end
            mCmd = (bitQ.size() > 0) ? bitQ.pop_front() : 1'b0;
            cyc++;
        end
    endtask

    task automatic applyStimulus();
        logic expReady;
        @(negedge CLK);
        expReady = ((cyc % 16) == 0) && EN && (sinceSync < SI - 1) && !RST;
        checkOutput("CMD_OUT", 16'(CMD_OUT), 16'(mCmd));
        checkOutput("BUSY", 16'(BUSY), 16'(mBusy));
        checkOutput("FRAME_READY", 16'(FRAME_READY), 16'(expReady));
        checkOutput("FRAME_CNT", FRAME_CNT, mCnt);
        seenBits = {seenBits[14:0], CMD_OUT};
        if (!RST && FRAME_READY && FRAME_VALID) begin
            dutAccepts++;
            dutAcceptCycle = cyc;
            if (dutAccepts == 32) dutAcc32Cycle = cyc;
        end
        modelAdvance();
        @(posedge CLK);
        #1;
    endtask

    // Linear sequence of directed scenarios with randomized payloads.
    initial begin
        int n;
        modelReset();
        dutAcceptCycle = -1;
        dutAcc32Cycle  = -1;
        EN = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        applyStimulus();
        applyStimulus();
        checkOutput("resetCmd", 16'(CMD_OUT), 16'h0000);
        checkOutput("resetCnt", FRAME_CNT, 16'h0000);

        // T1: idle link sends SYNC, 31 NOOPs, then SYNC again.
        $display("[TB] T1 idle link after reset");
        RST = 1'b0;
        repeat (17) applyStimulus();
        checkOutput("T1firstSync", seenBits, SYNC_W);
        repeat (16) applyStimulus();
        checkOutput("T1noop", seenBits, NOOP_W);
        repeat (496) applyStimulus();
        checkOutput("T1frame32Sync", seenBits, SYNC_W);

        // T2: a user frame waits behind the forced SYNC after release.
        $display("[TB] T2 first user frame");
        RST = 1'b1;
        applyStimulus();
        RST         = 1'b0;
        FRAME_VALID = 1'b1;
        FRAME_DATA  = 16'h1234;
        checkOutput("T2readyCycle0", 16'(FRAME_READY), 16'h0000);
        repeat (16) applyStimulus();
        checkOutput("T2readyCycle16", 16'(FRAME_READY), 16'h0001);
        applyStimulus();
        FRAME_VALID = 1'b0;
        checkOutput("T2count", FRAME_CNT, 16'h0001);
        repeat (16) applyStimulus();
        checkOutput("T2data", seenBits, 16'h1234);

        // T3: 40 back-to-back frames with one SYNC slot inserted.
        $display("[TB] T3 back-to-back stream");
        RST = 1'b1;
        applyStimulus();
        RST         = 1'b0;
        FRAME_VALID = 1'b1;
        FRAME_DATA  = 16'($urandom);
        n = 0;
        while (mCnt < 16'd40 && n < 800) begin
            applyStimulus();
            if (lastAccept) FRAME_DATA = 16'($urandom);
            n++;
        end
        checkOutput("T3count", FRAME_CNT, 16'd40);
        checkOutput("T3acc32Cycle", 16'(dutAcc32Cycle), 16'd528);

        // T4: EN low blocks accepts; EN rising mid-frame takes effect at next load.
        $display("[TB] T4 enable gating");
        EN = 1'b0;
        repeat (48) applyStimulus();
        checkOutput("T4noAccept", FRAME_CNT, 16'd40);
        n = 0;
        while ((cyc % 16) != 11 && n < 16) begin
            applyStimulus();
            n++;
        end
        EN = 1'b1;
        repeat (5) applyStimulus();
        checkOutput("T4beforeLoad", FRAME_CNT, 16'd40);
        applyStimulus();
        checkOutput("T4accept", FRAME_CNT, 16'd41);

        // T5: reset in the middle of a user frame aborts it.
        $display("[TB] T5 reset mid-frame");
        FRAME_DATA = 16'hA5A5;
        n = 0;
        do begin
            applyStimulus();
            n++;
        end while (!lastAccept && n < 20);
        checkOutput("T5accept", FRAME_CNT, 16'd42);
        FRAME_VALID = 1'b0;
        repeat (8) applyStimulus();
        checkOutput("T5bit7", 16'(CMD_OUT), 16'h0001);
        RST = 1'b1;
        applyStimulus();
        checkOutput("T5cmdAfterRst", 16'(CMD_OUT), 16'h0000);
        checkOutput("T5cntAfterRst", FRAME_CNT, 16'h0000);
        RST = 1'b0;
        repeat (17) applyStimulus();
        checkOutput("T5syncFirst", seenBits, SYNC_W);
        repeat (16) applyStimulus();
        checkOutput("T5noResend", seenBits, NOOP_W);

        // T6: a user SYNC restarts the cadence; counter wraps at 0xFFFF.
        $display("[TB] T6 user sync and counter wrap");
        RST = 1'b1;
        applyStimulus();
        RST = 1'b0;
        repeat (170) applyStimulus();
        FRAME_DATA  = SYNC_W;
        FRAME_VALID = 1'b1;
        n = 0;
        do begin
            applyStimulus();
            n++;
        end while (!lastAccept && n < 20);
        FRAME_VALID = 1'b0;
        checkOutput("T6userSyncCycle", 16'(dutAcceptCycle), 16'd176);
        while (cyc < 689 && n < 1000) begin
            applyStimulus();
            n++;
        end
        checkOutput("T6frame42Noop", seenBits, NOOP_W);
        repeat (16) applyStimulus();
        checkOutput("T6frame43Sync", seenBits, SYNC_W);
        force dut.frameCnt_q = 16'hFFFF;
        #1;
        release dut.frameCnt_q;
        mCnt = 16'hFFFF;
        checkOutput("T6forced", FRAME_CNT, 16'hFFFF);
        FRAME_DATA  = 16'($urandom);
        FRAME_VALID = 1'b1;
        n = 0;
        do begin
            applyStimulus();
            n++;
        end while (!lastAccept && n < 20);
        FRAME_VALID = 1'b0;
        checkOutput("T6wrap", FRAME_CNT, 16'h0000);
        repeat (20) applyStimulus();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
